hockey_core: RTL and testbench
==============================

HOCKEY_CORE -- requirements
Module: hockey_core

Interface
REQ-001 Parameter XW, default 5: field length in puck cells (x = 0 at A's goal line, x = XW-1 at B's), legal range 3..8.
REQ-002 Parameter YH, default 5: field height in rows (y = 0..YH-1), legal range 2..8.
REQ-003 Parameter WIN_SCORE, default 3: goals needed to win, legal range 1..15.
REQ-004 Parameter TICK_DIV, default 3: clock cycles per puck step, minimum 1.
REQ-005 Parameter RESP_WIN, default 3: response-window length in cycles, minimum 1.
REQ-006 Parameter HOLD, default 4: cycle count of DISP and GOAL display states.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 btn_a, btn_b  in  1 each  player buttons, already synchronised and debounced.
REQ-010 dir_a, dir_b  in  2 each  shot direction: 0 straight, 1 up (+y), 2 down (-y), 3 treated as straight.
REQ-011 y_a, y_b  in  3 each  player row selection.
REQ-012 x_coord, y_coord  out  3 each  puck position, registered.
REQ-013 score_a, score_b  out  4 each  goal counts, registered.
REQ-014 state  out  4  current FSM state encoding, for the display driver.
REQ-015 winner  out  2  game result: 0 none, 1 A, 2 B.

Function
REQ-016 The FSM shall have these states: IDLE, DISP, SERVE_A, SERVE_B, MOVE_AB, MOVE_BA, RESP_B, RESP_A, GOAL_A, GOAL_B, WIN.
REQ-017 IDLE, btn_a=1 and btn_b=0: the FSM shall record server=A and go to DISP; mirrored for B; both or neither pressed: stay in IDLE.
REQ-018 DISP shall last exactly HOLD cycles, then go to SERVE_A or SERVE_B according to server.
REQ-019 SERVE_A shall, on btn_a=1 with y_a<YH, load x=0, y=y_a, dir=dir_a and go to MOVE_AB; y_a>=YH shall be ignored.
REQ-020 SERVE_B shall mirror SERVE_A with x=XW-1 and go to MOVE_BA.
REQ-021 MOVE_AB shall step x by +1 every TICK_DIV cycles; MOVE_BA shall step x by -1.
REQ-022 On each step, y shall move by +1 (up) or -1 (down); at y=YH-1 going up, or y=0 going down, y shall hold and dir shall flip for the next step.
REQ-023 The step that lands on x=XW-1 shall also enter RESP_B; the step that lands on x=0 shall also enter RESP_A.
REQ-024 RESP_B shall last RESP_WIN cycles; a hit is any cycle in the window with btn_b=1 and y_b==y_coord.
REQ-025 RESP_B hit: the FSM shall go to MOVE_BA on the window's final cycle, with x=XW-2 and dir=dir_b latched at the hit.
REQ-026 RESP_B with no hit: score_a shall increment once and the FSM shall go to GOAL_A; RESP_A mirrors this (hit sets x=1, next state MOVE_AB; miss increments score_b, next state GOAL_B).
REQ-027 GOAL_x shall last HOLD cycles, then go to WIN if the scorer's count equals WIN_SCORE; otherwise the conceded player serves (GOAL_A -> SERVE_B, GOAL_B -> SERVE_A).
REQ-028 WIN shall set winner, hold every output, and ignore all inputs until rst.
REQ-029 Buttons already held when entering a SERVE or RESP state shall count (level-sensitive, no edge detection).
REQ-030 The tick and window counter shall clear on every state change; the first step shall occur TICK_DIV cycles after entering MOVE.

Reset
REQ-031 rst shall force IDLE, x_coord=0, y_coord=0, score_a=0, score_b=0, winner=0, dir=straight, counter=0, server=A, at any time including mid-flight.

Structure
REQ-032 A package hockey_pkg shall hold the state enum, the direction encodings and the winner encodings.
REQ-033 One sub-module, hockey_puck, shall own the x/y/dir registers and the bounce logic, and shall take step, load and hit controls from the FSM.

Verification
REQ-034 Defaults, A serves y=2 dir=1 -> y sequence 3,4,4(flip),3 as x goes 1..4; RESP_B entered on the cycle x=4.
REQ-035 Defaults, B presses btn_b with y_b matching y_coord in window cycle 2 -> MOVE_BA with x=3; no score change.
REQ-036 Defaults, B never presses -> score_a=1, GOAL_A lasts 4 cycles, then SERVE_B.
REQ-037 WIN_SCORE=1, first miss by A -> GOAL_B, then WIN with winner=2; later button presses change nothing.
REQ-038 btn_a and btn_b pressed together in IDLE -> stays IDLE; rst asserted during MOVE_AB -> all outputs zero next edge.
REQ-039 Sweep XW=8, YH=2, TICK_DIV=1 -> puck steps every cycle, bounces between rows 0 and 1.

Source files
------------

// File: rtl/hockey_pkg.sv
// hockey_pkg: shared FSM state, shot-direction and winner encodings for the hockey game.
package hockey_pkg;
  typedef enum logic [3:0] {
    IDLE, DISP, SERVE_A, SERVE_B, MOVE_AB, MOVE_BA, RESP_B, RESP_A, GOAL_A, GOAL_B, WIN
  } state_t;
  typedef enum logic [1:0] {DIR_STR = 2'd0, DIR_UP = 2'd1, DIR_DN = 2'd2} dir_t;
  typedef enum logic [1:0] {WNR_NONE = 2'd0, WNR_A = 2'd1, WNR_B = 2'd2} winner_t;
  // Code 3 on the direction inputs is played as a straight shot.
  function automatic dir_t norm_dir(input logic [1:0] d);
    return (d == 2'd3) ? DIR_STR : dir_t'(d);
  endfunction
endpackage

// File: rtl/hockey_puck.sv
// hockey_puck: puck position and direction registers with wall-bounce stepping.
module hockey_puck
  import hockey_pkg::*;
#(
  parameter int YH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [2:0] load_x,
  input  logic [2:0] load_y,
  input  dir_t       load_dir,
  input  logic       hit,
  input  logic [2:0] hit_x,
  input  dir_t       hit_dir,
  input  logic       step,
  input  logic       fwd,
  output logic [2:0] x,
  output logic [2:0] y
);
  dir_t dir, nd;
  logic top, bot;
  logic [2:0] ny;
  assign top = y == 3'(YH - 1);
  assign bot = y == 3'd0;
  // At a wall the row holds and only the direction reverses for the next step.
  assign ny = (dir == DIR_UP && !top) ? y + 3'd1 : (dir == DIR_DN && !bot) ? y - 3'd1 : y;
  assign nd = (dir == DIR_UP && top) ? DIR_DN : (dir == DIR_DN && bot) ? DIR_UP : dir;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      dir <= DIR_STR;
    end else if (load) begin
      x <= load_x;
      y <= load_y;
      dir <= load_dir;
    end else if (hit) begin
      x <= hit_x;
      dir <= hit_dir;
    end else if (step) begin
      x <= fwd ? x + 3'd1 : x - 3'd1;
      y <= ny;
      dir <= nd;
    end
  end
endmodule

// File: rtl/hockey_core.sv
// hockey_core: two-player hockey game FSM with serve, rally, response window, scoring and win.
module hockey_core
  import hockey_pkg::*;
#(
  parameter int XW        = 5,
  parameter int YH        = 5,
  parameter int WIN_SCORE = 3,
  parameter int TICK_DIV  = 3,
  parameter int RESP_WIN  = 3,
  parameter int HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic [1:0] dir_a,
  input  logic [1:0] dir_b,
  input  logic [2:0] y_a,
  input  logic [2:0] y_b,
  output logic [2:0] x_coord,
  output logic [2:0] y_coord,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] state,
  output logic [1:0] winner
);
  state_t cur, nxt;
  logic [15:0] cnt;
  logic server, hit_seen, tick, hold_done, win_end, ok_a, ok_b, hit_a, hit_b, got;
  logic load, hit, step, fwd;
  logic [2:0] load_x, load_y, hit_x;
  dir_t load_dir, hit_dir, hit_dir_q;
  assign state     = cur;
  assign tick      = cnt == 16'(TICK_DIV - 1);
  assign hold_done = cnt == 16'(HOLD - 1);
  assign win_end   = cnt == 16'(RESP_WIN - 1);
  assign ok_a      = btn_a && ({1'b0, y_a} < 4'(YH));
  assign ok_b      = btn_b && ({1'b0, y_b} < 4'(YH));
  assign hit_a     = btn_a && y_a == y_coord;
  assign hit_b     = btn_b && y_b == y_coord;
  // A hit earlier in the window or on its final cycle both count as a return.
  assign got       = hit_seen || (cur == RESP_B ? hit_b : hit_a);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= IDLE;
      cnt <= '0;
    end else begin
      cur <= nxt;
      cnt <= (nxt != cur || step) ? '0 : cnt + 16'd1;
    end
  end
  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:    nxt = (btn_a ^ btn_b) ? DISP : IDLE;
      DISP:    nxt = hold_done ? (server ? SERVE_B : SERVE_A) : DISP;
      SERVE_A: nxt = ok_a ? MOVE_AB : SERVE_A;
      SERVE_B: nxt = ok_b ? MOVE_BA : SERVE_B;
      MOVE_AB: nxt = (tick && x_coord == 3'(XW - 2)) ? RESP_B : MOVE_AB;
      MOVE_BA: nxt = (tick && x_coord == 3'd1) ? RESP_A : MOVE_BA;
      RESP_B:  nxt = win_end ? (got ? MOVE_BA : GOAL_A) : RESP_B;
      RESP_A:  nxt = win_end ? (got ? MOVE_AB : GOAL_B) : RESP_A;
      GOAL_A:  nxt = hold_done ? (score_a == 4'(WIN_SCORE) ? WIN : SERVE_B) : GOAL_A;
      GOAL_B:  nxt = hold_done ? (score_b == 4'(WIN_SCORE) ? WIN : SERVE_A) : GOAL_B;
      WIN:     nxt = WIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    load     = (cur == SERVE_A && ok_a) || (cur == SERVE_B && ok_b);
    load_x   = cur == SERVE_B ? 3'(XW - 1) : 3'd0;
    load_y   = cur == SERVE_B ? y_b : y_a;
    load_dir = norm_dir(cur == SERVE_B ? dir_b : dir_a);
    hit      = (cur == RESP_B || cur == RESP_A) && win_end && got;
    hit_x    = cur == RESP_B ? 3'(XW - 2) : 3'd1;
    hit_dir  = hit_seen ? hit_dir_q : norm_dir(cur == RESP_B ? dir_b : dir_a);
    step     = (cur == MOVE_AB || cur == MOVE_BA) && tick;
    fwd      = cur == MOVE_AB;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      server <= 1'b0;
      hit_seen <= 1'b0;
      hit_dir_q <= DIR_STR;
      score_a <= '0;
      score_b <= '0;
      winner <= WNR_NONE;
    end else begin
      if (cur == IDLE && nxt == DISP) server <= btn_b;
      hit_seen <= (nxt != cur) ? 1'b0 : hit_seen || (cur == RESP_B && hit_b) || (cur == RESP_A && hit_a);
      if (!hit_seen && ((cur == RESP_B && hit_b) || (cur == RESP_A && hit_a)))
        hit_dir_q <= norm_dir(cur == RESP_B ? dir_b : dir_a);
      if (cur == RESP_B && nxt == GOAL_A) score_a <= score_a + 4'd1;
      if (cur == RESP_A && nxt == GOAL_B) score_b <= score_b + 4'd1;
      if (nxt == WIN && cur != WIN) winner <= (cur == GOAL_A) ? WNR_A : WNR_B;
    end
  end
  hockey_puck #(.YH(YH)) u_puck (
    .clk(clk), .rst(rst),
    .load(load), .load_x(load_x), .load_y(load_y), .load_dir(load_dir),
    .hit(hit), .hit_x(hit_x), .hit_dir(hit_dir),
    .step(step), .fwd(fwd),
    .x(x_coord), .y(y_coord)
  );
endmodule

// File: tb/tb_hockey_core.sv
// tb_hockey_core: random full games against a game-level model; expected output changes are queued with their edge stamps.
module tb_hockey_core;
  import hockey_pkg::*;
  localparam int XW = 5, YH = 5, WS = 3, TD = 3, RW = 3, HD = 4;
  logic clk = 0, rst = 1, btn_a = 0, btn_b = 0;
  logic [1:0] dir_a = 0, dir_b = 0, winner;
  logic [2:0] y_a = 0, y_b = 0, x_coord, y_coord;
  logic [3:0] score_a, score_b, state;
  hockey_core #(.XW(XW), .YH(YH), .WIN_SCORE(WS), .TICK_DIV(TD), .RESP_WIN(RW), .HOLD(HD)) dut (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .dir_a(dir_a), .dir_b(dir_b),
    .y_a(y_a), .y_b(y_b), .x_coord(x_coord), .y_coord(y_coord), .score_a(score_a),
    .score_b(score_b), .state(state), .winner(winner)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] st; logic [2:0] x; logic [2:0] y; logic [3:0] sa; logic [3:0] sb; logic [1:0] w;
  } snap_t;
  snap_t exp_q[$], prev, mc, me;
  int stamp_q[$], ms, edges = 0, cmp = 0, bad = 0;
  bit mon_on = 0;
  int mx, my, mdir, sa, sb, mw;
  state_t mst;
  always @(posedge clk) edges <= edges + 1;
  // Monitor: any visible output change must match the next queued expectation and its edge.
  always @(negedge clk) begin
    mc = {state, x_coord, y_coord, score_a, score_b, winner};
    if (mon_on && mc != prev) begin
      cmp++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change got st=%0d x=%0d y=%0d sa=%0d sb=%0d w=%0d @%0d", mc.st, mc.x, mc.y, mc.sa, mc.sb, mc.w, edges);
      end else begin
        me = exp_q.pop_front();
        ms = stamp_q.pop_front();
        if (mc !== me || ms != edges) begin
          bad++;
          $display("FAIL event got st=%0d x=%0d y=%0d sa=%0d sb=%0d w=%0d @%0d want st=%0d x=%0d y=%0d sa=%0d sb=%0d w=%0d @%0d",
                   mc.st, mc.x, mc.y, mc.sa, mc.sb, mc.w, edges, me.st, me.x, me.y, me.sa, me.sb, me.w, ms);
        end
      end
    end
    prev = mc;
  end
  task automatic chk(input string n, input int got, input int want);
    cmp++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got %0d want %0d", n, got, want);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic expect_at(input int t);
    exp_q.push_back({4'(mst), 3'(mx), 3'(my), 4'(sa), 4'(sb), 2'(mw)});
    stamp_q.push_back(t);
  endtask
  task automatic noise();
    btn_a = 1'($urandom_range(0, 1)); btn_b = 1'($urandom_range(0, 1));
    y_a = 3'($urandom); y_b = 3'($urandom); dir_a = 2'($urandom); dir_b = 2'($urandom);
  endtask
  task automatic quiet();
    btn_a = 0; btn_b = 0;
  endtask
  task automatic model_reset();
    mst = IDLE; mx = 0; my = 0; mdir = 0; sa = 0; sb = 0; mw = 0;
  endtask
  function automatic void stepy();
    if (mdir == 1) begin
      if (my == YH - 1) mdir = 2; else my++;
    end else if (mdir == 2) begin
      if (my == 0) mdir = 1; else my--;
    end
  endfunction
  task automatic check_zero(input string n);
    chk({n, "_state"}, state, IDLE); chk({n, "_x"}, x_coord, 0); chk({n, "_y"}, y_coord, 0);
    chk({n, "_sa"}, score_a, 0); chk({n, "_sb"}, score_b, 0); chk({n, "_winner"}, winner, 0);
  endtask
  task automatic start_game(input int force_srv, output bit srv);
    repeat ($urandom_range(0, 3)) begin
      btn_a = 1'($urandom_range(0, 1)); btn_b = btn_a; cyc(1);
    end
    srv = (force_srv >= 0) ? 1'(force_srv) : 1'($urandom_range(0, 1));
    btn_a = !srv; btn_b = srv;
    mst = DISP; expect_at(edges + 1); cyc(1); quiet();
    mst = srv ? SERVE_B : SERVE_A; expect_at(edges + HD); cyc(HD);
  endtask
  task automatic serve(input bit srv);
    int yy, d;
    repeat ($urandom_range(0, 3)) begin
      noise();
      if (srv) begin
        btn_b = (YH < 8); y_b = 3'($urandom_range(YH, 7));
      end else begin
        btn_a = (YH < 8); y_a = 3'($urandom_range(YH, 7));
      end
      cyc(1);
    end
    noise();
    yy = $urandom_range(0, YH - 1); d = $urandom_range(0, 3);
    if (srv) begin btn_b = 1; y_b = 3'(yy); dir_b = 2'(d); end
    else begin btn_a = 1; y_a = 3'(yy); dir_a = 2'(d); end
    mst = srv ? MOVE_BA : MOVE_AB; mx = srv ? XW - 1 : 0; my = yy; mdir = (d == 3) ? 0 : d;
    expect_at(edges + 1); cyc(1); quiet();
  endtask
  task automatic fly();
    int t = edges;
    int dx = (mst == MOVE_AB) ? 1 : -1;
    int n = (dx > 0) ? XW - 1 - mx : mx;
    for (int k = 1; k <= n; k++) begin
      mx += dx; stepy();
      if (k == n) mst = (dx > 0) ? RESP_B : RESP_A;
      expect_at(t + k * TD);
    end
    repeat (n * TD) begin noise(); cyc(1); end
  endtask
  // res: 0 rally continues, 1 goal then serve, 2 game won
  task automatic resp(output int res);
    bit rb, bb;
    int hw, hd, yc;
    logic [2:0] yy;
    rb = (mst == RESP_B); yc = my;
    hw = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, RW - 1)) : -1;
    hd = $urandom_range(0, 3);
    if (hw >= 0) begin
      mst = rb ? MOVE_BA : MOVE_AB; mx = rb ? XW - 2 : 1; mdir = (hd == 3) ? 0 : hd; res = 0;
    end else begin
      if (rb) begin sa++; mst = GOAL_A; end else begin sb++; mst = GOAL_B; end
      res = 1;
    end
    expect_at(edges + RW);
    for (int w = 0; w < RW; w++) begin
      noise();
      if (w == hw) begin bb = 1; yy = 3'(yc); end
      else if ($urandom_range(0, 1) == 1) begin bb = 1; yy = 3'(yc + 1 + int'($urandom_range(0, 6))); end
      else begin bb = 0; yy = 3'(yc); end
      if (rb) begin btn_b = bb; y_b = yy; if (w == hw) dir_b = 2'(hd); end
      else begin btn_a = bb; y_a = yy; if (w == hw) dir_a = 2'(hd); end
      cyc(1);
    end
    if (res == 1) begin
      if ((rb ? sa : sb) == WS) begin
        mst = WIN; mw = rb ? 1 : 2; res = 2;
      end else mst = rb ? SERVE_B : SERVE_A;
      expect_at(edges + HD);
      repeat (HD) begin noise(); cyc(1); end
    end
  endtask
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $fatal(1, "timeout");
  end
  initial begin
    bit srv;
    int res, rallies, t;
    model_reset();
    rst = 1;
    cyc(2);
    check_zero("reset");
    rst = 0;
    cyc(1);
    mon_on = 1;
    start_game(-1, srv);
    res = 1; rallies = 0;
    while (res != 2 && rallies < 300) begin
      serve(srv);
      res = 0;
      while (res == 0) begin fly(); resp(res); end
      rallies++;
      srv = (mst == SERVE_B);
    end
    chk("reached_win", res, 2);
    repeat (20) begin noise(); cyc(1); end
    quiet();
    chk("win_queue_drained", exp_q.size(), 0);
    chk("win_winner", winner, mw);
    chk("win_state", state, WIN);
    mon_on = 0; rst = 1; #1;
    check_zero("async_rst");
    @(negedge clk); rst = 0; model_reset();
    cyc(1); mon_on = 1;
    btn_a = 1; btn_b = 1; cyc(5); quiet();
    chk("idle_both_pressed", state, IDLE);
    start_game(0, srv);
    serve(0);
    t = edges; mx += 1; stepy(); expect_at(t + TD);
    cyc(TD + 1);
    chk("move_queue_drained", exp_q.size(), 0);
    chk("move_state_before_rst", state, MOVE_AB);
    mon_on = 0; rst = 1;
    @(posedge clk); #1;
    check_zero("midflight_rst");
    @(negedge clk); rst = 0; model_reset();
    cyc(1); mon_on = 1;
    start_game(1, srv);
    cyc(2);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
